// File: rtl/alu_iq_pkg.sv
// Shared defaults and entry layout for the ALU issue queue.
package alu_iq_pkg;

  localparam int IQ_DEPTH = 4;
  localparam int IQ_PHY_W = 6;
  localparam int IQ_CW_W  = 4;
  localparam int IQ_OP_W  = 6;

  // Field widths track the package defaults; the queue is built with these widths.
  typedef struct packed {
    logic                valid;
    logic [IQ_OP_W-1:0]  op;
    logic [31:0]         imm;
    logic [IQ_PHY_W-1:0] tag1;
    logic                rdy1;
    logic [31:0]         val1;
    logic [IQ_PHY_W-1:0] tag2;
    logic                rdy2;
    logic [31:0]         val2;
    logic [IQ_PHY_W-1:0] phydst;
    logic [IQ_CW_W-1:0]  cw;
  } iq_entry_t;

endpackage

// File: rtl/alu_issue_queue_select.sv
// Fixed-priority picker: lowest ready index wins, which is the oldest entry.
module iq_oldest_ready_select #(
  parameter  int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Compacting, age-ordered reservation station for the single ALU pipe.
// Entry 0 is oldest; wakeup, removal and insertion all resolve in one edge.
module alu_issue_queue
  import alu_iq_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PHY_W = IQ_PHY_W,
  parameter int CW_W  = IQ_CW_W,
  parameter int OP_W  = IQ_OP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [31:0]              disp_imm,
  input  logic [PHY_W-1:0]         disp_src1_tag,
  input  logic [PHY_W-1:0]         disp_src2_tag,
  input  logic                     disp_src1_rdy,
  input  logic                     disp_src2_rdy,
  input  logic [31:0]              disp_src1_val,
  input  logic [31:0]              disp_src2_val,
  input  logic [PHY_W-1:0]         disp_phydst,
  input  logic [CW_W-1:0]          disp_cw,
  input  logic                     wb_valid,
  input  logic [PHY_W-1:0]         wb_phydst,
  input  logic [31:0]              wb_result,
  output logic                     EX_en,
  output logic [OP_W-1:0]          EX_Operation,
  output logic [31:0]              EX_imm,
  output logic [31:0]              EX_Src1,
  output logic [31:0]              EX_Src2,
  output logic [PHY_W-1:0]         EX_Phydst,
  output logic [CW_W-1:0]          EX_Commit_Window,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  iq_entry_t        q     [DEPTH];
  iq_entry_t        woken [DEPTH];
  iq_entry_t        up    [DEPTH];
  iq_entry_t        q_nxt [DEPTH];
  iq_entry_t        sel_e;
  iq_entry_t        new_e;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] wr_idx;
  logic [DEPTH-1:0] rdy_vec;
  logic [DEPTH-1:0] grant;
  logic [DEPTH-1:0] shift_mask;
  logic [IDX_W-1:0] sel_idx;
  logic             found;
  logic             issue;
  logic             accept;

  // Readiness depends only on registered occupancy, never on this cycle's issue.
  assign disp_ready = (occ < OCC_W'(DEPTH));
  assign accept     = disp_valid & disp_ready & ~flush;
  assign occupancy  = occ;

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      rdy_vec[i] = q[i].valid & q[i].rdy1 & q[i].rdy2;
  end

  iq_oldest_ready_select #(.DEPTH(DEPTH)) u_select (
    .ready (rdy_vec),
    .grant (grant),
    .idx   (sel_idx),
    .found (found)
  );

  assign issue = found & ~flush;

  // With nothing found the select index is 0, so the outputs show entry 0.
  assign sel_e            = q[sel_idx];
  assign EX_en            = issue;
  assign EX_Operation     = sel_e.op;
  assign EX_imm           = sel_e.imm;
  assign EX_Src1          = sel_e.val1;
  assign EX_Src2          = sel_e.val2;
  assign EX_Phydst        = sel_e.phydst;
  assign EX_Commit_Window = sel_e.cw;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = q[i];
      if (wb_valid && q[i].valid) begin
        if (!q[i].rdy1 && (q[i].tag1 == wb_phydst)) begin
          woken[i].rdy1 = 1'b1;
          woken[i].val1 = wb_result;
        end
        if (!q[i].rdy2 && (q[i].tag2 == wb_phydst)) begin
          woken[i].rdy2 = 1'b1;
          woken[i].val2 = wb_result;
        end
      end
    end
  end

  // The incoming op snoops the same broadcast so it cannot miss its producer.
  always_comb begin
    new_e        = '0;
    new_e.valid  = 1'b1;
    new_e.op     = disp_op;
    new_e.imm    = disp_imm;
    new_e.tag1   = disp_src1_tag;
    new_e.tag2   = disp_src2_tag;
    new_e.phydst = disp_phydst;
    new_e.cw     = disp_cw;
    new_e.rdy1   = disp_src1_rdy;
    new_e.val1   = disp_src1_val;
    new_e.rdy2   = disp_src2_rdy;
    new_e.val2   = disp_src2_val;
    if (wb_valid && !disp_src1_rdy && (disp_src1_tag == wb_phydst)) begin
      new_e.rdy1 = 1'b1;
      new_e.val1 = wb_result;
    end
    if (wb_valid && !disp_src2_rdy && (disp_src2_tag == wb_phydst)) begin
      new_e.rdy2 = 1'b1;
      new_e.val2 = wb_result;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++)
      up[i] = woken[i+1];
    up[DEPTH-1] = '0;
  end

  // One-hot grant minus one leaves ones below it; inverting marks the issued slot and above.
  assign shift_mask = ~(grant - {{(DEPTH-1){1'b0}}, 1'b1});
  assign wr_idx     = occ - OCC_W'(issue);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = (issue && shift_mask[i]) ? up[i] : woken[i];
      if (accept && (wr_idx == OCC_W'(i)))
        q_nxt[i] = new_e;
    end
  end

  // Whole entries are cleared so the idle EX bundle reads as zero after reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ <= '0;
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
    end else begin
      occ <= occ + OCC_W'(accept) - OCC_W'(issue);
      for (int i = 0; i < DEPTH; i++)
        q[i] <= q_nxt[i];
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with an in-order issue scoreboard.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int PHY_W = 6;
  localparam int CW_W  = 4;
  localparam int OP_W  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, flush;
  logic                    disp_valid, disp_ready;
  logic [OP_W-1:0]         disp_op;
  logic [31:0]             disp_imm;
  logic [PHY_W-1:0]        disp_src1_tag, disp_src2_tag;
  logic                    disp_src1_rdy, disp_src2_rdy;
  logic [31:0]             disp_src1_val, disp_src2_val;
  logic [PHY_W-1:0]        disp_phydst;
  logic [CW_W-1:0]         disp_cw;
  logic                    wb_valid;
  logic [PHY_W-1:0]        wb_phydst;
  logic [31:0]             wb_result;
  logic                    EX_en;
  logic [OP_W-1:0]         EX_Operation;
  logic [31:0]             EX_imm, EX_Src1, EX_Src2;
  logic [PHY_W-1:0]        EX_Phydst;
  logic [CW_W-1:0]         EX_Commit_Window;
  logic [$clog2(DEPTH):0]  occupancy;

  alu_issue_queue #(.DEPTH(DEPTH), .PHY_W(PHY_W), .CW_W(CW_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_imm(disp_imm),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
    .disp_phydst(disp_phydst), .disp_cw(disp_cw),
    .wb_valid(wb_valid), .wb_phydst(wb_phydst), .wb_result(wb_result),
    .EX_en(EX_en), .EX_Operation(EX_Operation), .EX_imm(EX_imm),
    .EX_Src1(EX_Src1), .EX_Src2(EX_Src2), .EX_Phydst(EX_Phydst),
    .EX_Commit_Window(EX_Commit_Window), .occupancy(occupancy)
  );

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [31:0]      imm;
    logic [31:0]      s1;
    logic [31:0]      s2;
    logic [PHY_W-1:0] pd;
    logic [CW_W-1:0]  cw;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wb_valid   = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [31:0] imm,
                      input logic [PHY_W-1:0] t1, input logic r1, input logic [31:0] v1,
                      input logic [PHY_W-1:0] t2, input logic r2, input logic [31:0] v2,
                      input logic [PHY_W-1:0] pd, input logic [CW_W-1:0] cw);
    disp_valid    = 1'b1;
    disp_op       = op;
    disp_imm      = imm;
    disp_src1_tag = t1;
    disp_src1_rdy = r1;
    disp_src1_val = v1;
    disp_src2_tag = t2;
    disp_src2_rdy = r2;
    disp_src2_val = v2;
    disp_phydst   = pd;
    disp_cw       = cw;
  endtask

  task automatic wb(input logic [PHY_W-1:0] t, input logic [31:0] v);
    wb_valid  = 1'b1;
    wb_phydst = t;
    wb_result = v;
  endtask

  task automatic expect_issue(input logic [OP_W-1:0] op, input logic [31:0] imm,
                              input logic [31:0] s1, input logic [31:0] s2,
                              input logic [PHY_W-1:0] pd, input logic [CW_W-1:0] cw);
    exp_t e;
    e.op = op; e.imm = imm; e.s1 = s1; e.s2 = s2; e.pd = pd; e.cw = cw;
    sb.push_back(e);
  endtask

  // Every issued op must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (EX_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("issue_with_empty_sb", {31'd0, EX_en}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ex_op",  32'(EX_Operation),     32'(e.op));
        chk("ex_imm", EX_imm,                e.imm);
        chk("ex_src1", EX_Src1,              e.s1);
        chk("ex_src2", EX_Src2,              e.s2);
        chk("ex_phydst", 32'(EX_Phydst),     32'(e.pd));
        chk("ex_cw", 32'(EX_Commit_Window),  32'(e.cw));
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    disp_valid = 1'b0;
    wb_phydst  = '0;
    wb_result  = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_ready", 32'(disp_ready), 1);
    chk("rst_en", 32'(EX_en), 0);
    chk("rst_src1", EX_Src1, 0);
    chk("rst_phydst", 32'(EX_Phydst), 0);
    step();

    // Single ready op issues the cycle after it is accepted.
    idle(); disp(6'h01, 5, 0, 1, 10, 0, 1, 20, 7, 3); expect_issue(6'h01, 5, 10, 20, 7, 3); step();
    idle(); @(negedge clk); chk("t1_en", 32'(EX_en), 1); chk("t1_occ", 32'(occupancy), 1); step();
    idle(); @(negedge clk); chk("t1_occ0", 32'(occupancy), 0); chk("t1_en0", 32'(EX_en), 0); step();

    // Younger ready op bypasses an older waiting one.
    idle(); disp(6'h02, 32'h100, 9, 0, 0, 0, 1, 32'h22, 8, 4); step();
    idle(); disp(6'h03, 32'h200, 0, 1, 1, 0, 1, 2, 10, 5); expect_issue(6'h03, 32'h200, 1, 2, 10, 5);
    @(negedge clk); chk("t2_a_wait", 32'(EX_en), 0); step();
    idle(); @(negedge clk); chk("t2_b_en", 32'(EX_en), 1); chk("t2_occ2", 32'(occupancy), 2); step();
    idle(); wb(9, 32'h55); expect_issue(6'h02, 32'h100, 32'h55, 32'h22, 8, 4);
    @(negedge clk); chk("t2_no_same_cycle", 32'(EX_en), 0); chk("t2_occ1", 32'(occupancy), 1); step();
    idle(); @(negedge clk); chk("t2_a_en", 32'(EX_en), 1); chk("t2_a_src1", EX_Src1, 32'h55); step();
    idle(); @(negedge clk); chk("t2_occ0", 32'(occupancy), 0); step();

    // Dispatch bypass; src1 already ready on the same tag keeps its own value.
    idle(); disp(6'h04, 3, 12, 1, 32'h11, 12, 0, 0, 11, 6); wb(12, 32'hAB);
    expect_issue(6'h04, 3, 32'h11, 32'hAB, 11, 6); step();
    idle(); @(negedge clk); chk("t3_en", 32'(EX_en), 1); chk("t3_src2", EX_Src2, 32'hAB); step();
    idle(); @(negedge clk); chk("t3_occ0", 32'(occupancy), 0); step();

    // Fill, reject while full, wake the middle entry, then drain in age order.
    for (int k = 0; k < 4; k++) begin
      idle();
      disp(OP_W'(5 + k), 32'(k), PHY_W'(20 + k), 0, 0, 0, 1, 32'(100 + k), PHY_W'(30 + k), CW_W'(k));
      step();
    end
    idle(); disp(6'h3F, 32'hF, 0, 1, 32'hEE, 0, 1, 32'hEE, 40, 9);
    @(negedge clk); chk("t4_full_ready", 32'(disp_ready), 0); chk("t4_occ4", 32'(occupancy), 4);
    chk("t4_full_en", 32'(EX_en), 0); step();
    idle(); wb(22, 32'h222); expect_issue(6'h07, 2, 32'h222, 102, 32, 2);
    @(negedge clk); chk("t4_ignored_occ", 32'(occupancy), 4); chk("t4_ignored_en", 32'(EX_en), 0); step();
    idle(); @(negedge clk); chk("t4_mid_en", 32'(EX_en), 1); chk("t4_mid_pd", 32'(EX_Phydst), 32);
    chk("t4_issue_full_ready", 32'(disp_ready), 0); step();
    idle(); wb(20, 32'h220); expect_issue(6'h05, 0, 32'h220, 100, 30, 0);
    @(negedge clk); chk("t4_occ3", 32'(occupancy), 3); chk("t4_ready1", 32'(disp_ready), 1);
    chk("t4_en0", 32'(EX_en), 0); step();
    idle(); wb(21, 32'h221); expect_issue(6'h06, 1, 32'h221, 101, 31, 1);
    @(negedge clk); chk("t4_e0_pd", 32'(EX_Phydst), 30); step();
    idle(); wb(23, 32'h223); expect_issue(6'h08, 3, 32'h223, 103, 33, 3);
    @(negedge clk); chk("t4_e1_pd", 32'(EX_Phydst), 31); step();
    idle(); @(negedge clk); chk("t4_e3_pd", 32'(EX_Phydst), 33); step();
    idle(); @(negedge clk); chk("t4_drained", 32'(occupancy), 0); step();

    // Two ready entries plus a simultaneous dispatch.
    idle(); disp(6'h09, 32'h10, 30, 0, 0, 0, 1, 32'h31, 41, 7); step();
    idle(); disp(6'h0A, 32'h20, 30, 0, 0, 0, 1, 32'h32, 42, 8); step();
    idle(); wb(30, 32'h3030);
    expect_issue(6'h09, 32'h10, 32'h3030, 32'h31, 41, 7);
    expect_issue(6'h0A, 32'h20, 32'h3030, 32'h32, 42, 8);
    @(negedge clk); chk("t5_wait", 32'(EX_en), 0); step();
    idle(); disp(6'h0B, 32'h30, 0, 1, 32'h41, 0, 1, 32'h42, 43, 9);
    expect_issue(6'h0B, 32'h30, 32'h41, 32'h42, 43, 9);
    @(negedge clk); chk("t5_p_pd", 32'(EX_Phydst), 41); chk("t5_occ2", 32'(occupancy), 2); step();
    idle(); @(negedge clk); chk("t5_q_pd", 32'(EX_Phydst), 42); chk("t5_occ_same", 32'(occupancy), 2); step();
    idle(); @(negedge clk); chk("t5_r_pd", 32'(EX_Phydst), 43); chk("t5_occ1", 32'(occupancy), 1); step();
    idle(); @(negedge clk); chk("t5_occ0", 32'(occupancy), 0); step();

    // Flush while an entry would issue.
    idle(); disp(6'h0C, 0, 40, 0, 0, 0, 1, 1, 44, 1); step();
    idle(); disp(6'h0D, 0, 41, 0, 0, 0, 1, 1, 45, 2); step();
    idle(); disp(6'h0E, 0, 0, 1, 5, 0, 1, 6, 46, 3); step();
    idle(); flush = 1'b1;
    @(negedge clk); chk("t6_flush_en", 32'(EX_en), 0); chk("t6_occ3", 32'(occupancy), 3); step();
    idle(); wb(40, 32'h4040);
    @(negedge clk); chk("t6_occ0", 32'(occupancy), 0); chk("t6_ready", 32'(disp_ready), 1);
    chk("t6_en0", 32'(EX_en), 0); step();
    idle(); @(negedge clk); chk("t6_stale_wb", 32'(EX_en), 0); step();

    // Reset mid-operation.
    idle(); disp(6'h0F, 0, 50, 0, 0, 50, 0, 0, 47, 4); step();
    idle(); disp(6'h10, 0, 51, 0, 0, 0, 1, 0, 48, 5); step();
    idle(); rst = 1'b1; @(negedge clk); chk("t7_pre_occ", 32'(occupancy), 2); step();
    rst = 1'b0; idle(); wb(50, 32'h5050);
    @(negedge clk); chk("t7_occ0", 32'(occupancy), 0); chk("t7_ready", 32'(disp_ready), 1);
    chk("t7_en0", 32'(EX_en), 0); step();
    idle(); @(negedge clk); chk("t7_stale_wb", 32'(EX_en), 0); step();

    // Unmatched broadcast, then both sources woken by one tag.
    idle(); disp(6'h11, 32'h55, 60, 0, 0, 60, 0, 0, 49, 10); step();
    idle(); wb(62, 32'hDEAD); @(negedge clk); chk("t8_wait", 32'(EX_en), 0); step();
    idle(); wb(60, 32'h6060); expect_issue(6'h11, 32'h55, 32'h6060, 32'h6060, 49, 10);
    @(negedge clk); chk("t8_nomatch_en", 32'(EX_en), 0); chk("t8_occ1", 32'(occupancy), 1); step();
    idle(); @(negedge clk); chk("t8_en", 32'(EX_en), 1); chk("t8_src1", EX_Src1, 32'h6060); step();
    idle(); @(negedge clk); chk("t8_occ0", 32'(occupancy), 0); step();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
